// File: rtl/cache_control.sv
// cache_control: sequencing controller for the 2-way set-associative,
// write-back, 8-set cache datapath. Drives the datapath selects and write
// strobes, runs the memory writeback/fill handshakes and counts hits/misses.
module cache_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpu_read,
  input  logic        i_cpu_write,
  output logic        o_cpu_resp,
  output logic        o_mem_read,
  output logic        o_mem_write,
  input  logic        i_mem_resp,
  input  logic        i_hit0,
  input  logic        i_hit1,
  input  logic        i_lru_out,
  input  logic        i_dir0_out,
  input  logic        i_dir1_out,
  output logic        o_indata_muxsel,
  output logic        o_outdata_muxsel,
  output logic [1:0]  o_memaddr_muxsel,
  output logic        o_lru_we,
  output logic        o_lru_in,
  output logic        o_val_in,
  output logic        o_dir_in,
  output logic        o_write0,
  output logic        o_write1,
  output logic [15:0] o_hit_count,
  output logic [15:0] o_miss_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TAG   = 2'd1,
    S_WB    = 2'd2,
    S_ALLOC = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_victim;
  logic             r_refill;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  logic w_req;
  logic w_hit;
  logic w_hit_way;
  logic w_victim_dirty;

  // Request/hit decode; way 0 wins when both tags (illegally) match.
  assign w_req          = i_cpu_read | i_cpu_write;
  assign w_hit          = i_hit0 | i_hit1;
  assign w_hit_way      = ~i_hit0;
  assign w_victim_dirty = i_lru_out ? i_dir1_out : i_dir0_out;

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

  // State, latched victim, refill flag and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_victim     <= 1'b0;
      r_refill     <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) r_state <= S_TAG;
        end
        S_TAG: begin
          // A fill's re-check is not a new hit; the flag lives for one TAG visit.
          r_refill <= 1'b0;
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (w_hit) begin
            r_state <= S_IDLE;
            if (!r_refill && (r_hit_count != CNT_MAX))
              r_hit_count <= r_hit_count + CNT_W'(1);
          end else begin
            r_victim <= i_lru_out;
            if (r_miss_count != CNT_MAX)
              r_miss_count <= r_miss_count + CNT_W'(1);
            r_state <= w_victim_dirty ? S_WB : S_ALLOC;
          end
        end
        S_WB: begin
          if (i_mem_resp) r_state <= S_ALLOC;
        end
        S_ALLOC: begin
          if (i_mem_resp) begin
            r_refill <= 1'b1;
            r_state  <= S_TAG;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath control decode from current state, victim and live inputs.
  always_comb begin
    o_cpu_resp       = 1'b0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_indata_muxsel  = 1'b0;
    o_outdata_muxsel = 1'b0;
    o_memaddr_muxsel = 2'd0;
    o_lru_we         = 1'b0;
    o_lru_in         = 1'b0;
    o_val_in         = 1'b0;
    o_dir_in         = 1'b0;
    o_write0         = 1'b0;
    o_write1         = 1'b0;
    case (r_state)
      S_TAG: begin
        if (w_req && w_hit) begin
          o_outdata_muxsel = w_hit_way;
          o_lru_we         = 1'b1;
          o_lru_in         = ~w_hit_way;
          o_cpu_resp       = 1'b1;
          if (i_cpu_write) begin
            o_write0        = ~w_hit_way;
            o_write1        = w_hit_way;
            o_indata_muxsel = 1'b1;
            o_val_in        = 1'b1;
            o_dir_in        = 1'b1;
          end
        end
      end
      S_WB: begin
        o_mem_write      = 1'b1;
        o_memaddr_muxsel = r_victim ? 2'd2 : 2'd1;
        o_outdata_muxsel = r_victim;
      end
      S_ALLOC: begin
        o_mem_read       = 1'b1;
        o_memaddr_muxsel = 2'd0;
        if (i_mem_resp) begin
          o_write0 = ~r_victim;
          o_write1 = r_victim;
          o_val_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control with a response scoreboard.
module tb_cache_control;

  logic        clk;
  logic        rst_n;
  logic        cpu_read, cpu_write, mem_resp;
  logic        hit0, hit1, lru_out, dir0_out, dir1_out;
  logic        cpu_resp, mem_read, mem_write;
  logic        indata_muxsel, outdata_muxsel;
  logic [1:0]  memaddr_muxsel;
  logic        lru_we, lru_in, val_in, dir_in, write0, write1;
  logic [15:0] hit_count, miss_count;

  cache_control dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cpu_read       (cpu_read),
    .i_cpu_write      (cpu_write),
    .o_cpu_resp       (cpu_resp),
    .o_mem_read       (mem_read),
    .o_mem_write      (mem_write),
    .i_mem_resp       (mem_resp),
    .i_hit0           (hit0),
    .i_hit1           (hit1),
    .i_lru_out        (lru_out),
    .i_dir0_out       (dir0_out),
    .i_dir1_out       (dir1_out),
    .o_indata_muxsel  (indata_muxsel),
    .o_outdata_muxsel (outdata_muxsel),
    .o_memaddr_muxsel (memaddr_muxsel),
    .o_lru_we         (lru_we),
    .o_lru_in         (lru_in),
    .o_val_in         (val_in),
    .o_dir_in         (dir_in),
    .o_write0         (write0),
    .o_write1         (write1),
    .o_hit_count      (hit_count),
    .o_miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All control outputs packed in a fixed order for compact comparison.
  logic [12:0] ctl;
  assign ctl = {cpu_resp, mem_read, mem_write, indata_muxsel, outdata_muxsel,
                memaddr_muxsel, lru_we, lru_in, val_in, dir_in, write0, write1};

  typedef struct {
    bit          wr;
    bit          way;
    logic [15:0] hc;
    logic [15:0] mc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_hit, m_miss;
  int          n_checks, n_fail;

  function automatic logic [12:0] mk(bit resp, bit mrd, bit mwr, bit indat,
                                     bit outdat, logic [1:0] ma, bit lwe,
                                     bit lin, bit vin, bit din, bit w0, bit w1);
    return {resp, mrd, mwr, indat, outdat, ma, lwe, lin, vin, din, w0, w1};
  endfunction

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Pop the expected response, compare the TAG-hit cycle, then the idle cycle after.
  task automatic check_resp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed cpu_resp with empty scoreboard expected a queued entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, " resp"}, 32'(ctl),
          32'(mk(1'b1, 1'b0, 1'b0, e.wr, e.way, 2'd0, 1'b1, ~e.way,
                 e.wr, e.wr, e.wr & ~e.way, e.wr & e.way)));
    cyc();
    cpu_read = 1'b0; cpu_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    settle();
    check({tag, " after ctl"}, 32'(ctl), 32'd0);
    check({tag, " hit_count"}, 32'(hit_count), 32'(e.hc));
    check({tag, " miss_count"}, 32'(miss_count), 32'(e.mc));
  endtask

  // One complete CPU request: hit, clean miss or dirty miss.
  task automatic xact(input string tag, input bit wr, input bit [1:0] hits,
                      input bit lru, input bit d0, input bit d1,
                      input int wb_lat, input int fill_lat);
    bit   hit, victim, dirty, way;
    exp_t e;
    hit    = |hits;
    victim = lru;
    dirty  = victim ? d1 : d0;
    way    = hit ? ~hits[0] : victim;
    if (hit) m_hit = sat_inc(m_hit);
    else     m_miss = sat_inc(m_miss);
    e.wr = wr; e.way = way; e.hc = m_hit; e.mc = m_miss;
    sb.push_back(e);

    cyc();
    cpu_read = ~wr; cpu_write = wr;
    settle();
    check({tag, " idle"}, 32'(ctl), 32'd0);
    cyc();
    hit0 = hits[0]; hit1 = hits[1]; lru_out = lru; dir0_out = d0; dir1_out = d1;
    settle();
    if (!hit) begin
      check({tag, " tag miss"}, 32'(ctl), 32'd0);
      cyc();
      hit0 = 1'b0; hit1 = 1'b0;
      if (dirty) begin
        for (int i = 0; i <= wb_lat; i++) begin
          mem_resp = (i == wb_lat);
          settle();
          check({tag, " wb"}, 32'(ctl),
                32'(mk(1'b0, 1'b0, 1'b1, 1'b0, victim, victim ? 2'd2 : 2'd1,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
          cyc();
        end
        mem_resp = 1'b0;
      end
      for (int i = 0; i <= fill_lat; i++) begin
        bit r;
        r = (i == fill_lat);
        mem_resp = r;
        settle();
        check({tag, " alloc"}, 32'(ctl),
              32'(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0,
                     r, 1'b0, r & ~victim, r & victim)));
        cyc();
      end
      mem_resp = 1'b0;
      hit0 = ~victim; hit1 = victim;
      settle();
    end
    check_resp(tag);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_hit = 16'd0; m_miss = 16'd0;
    rst_n = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; mem_resp = 1'b0;
    hit0 = 1'b0; hit1 = 1'b0; lru_out = 1'b0; dir0_out = 1'b0; dir1_out = 1'b0;

    // Reset state
    #3;
    check("reset ctl", 32'(ctl), 32'd0);
    check("reset hit_count", 32'(hit_count), 32'd0);
    check("reset miss_count", 32'(miss_count), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Clean miss to empty set, hits on two ways, dirty misses, both-hit priority
    xact("rd clean miss", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0, 2);
    xact("rd hit w1",     1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0);
    xact("wr hit w0",     1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 0, 0);
    xact("wr dirty w1",   1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 3, 1);
    xact("rd both hit",   1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 0, 0);
    xact("wr dirty w0",   1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 0, 0);
    xact("rd clean w1",   1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 0, 3);

    // Request dropped during ALLOC: fill completes, no response, no hit counted
    cyc();
    cpu_write = 1'b1;
    settle();
    cyc();
    hit0 = 1'b0; hit1 = 1'b0; lru_out = 1'b0; dir0_out = 1'b0; dir1_out = 1'b0;
    settle();
    m_miss = sat_inc(m_miss);
    cyc();
    cpu_write = 1'b0;
    settle();
    check("drop alloc", 32'(ctl), 32'(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0,
                                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
    cyc();
    mem_resp = 1'b1;
    settle();
    check("drop fill", 32'(ctl), 32'(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0,
                                         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)));
    cyc();
    mem_resp = 1'b0; hit0 = 1'b1;
    settle();
    check("drop tag", 32'(ctl), 32'd0);
    cyc();
    hit0 = 1'b0;
    settle();
    check("drop idle", 32'(ctl), 32'd0);
    check("drop hit_count", 32'(hit_count), 32'(m_hit));
    check("drop miss_count", 32'(miss_count), 32'(m_miss));

    // Reset asserted in the middle of a dirty writeback
    cyc();
    cpu_read = 1'b1;
    settle();
    cyc();
    lru_out = 1'b1; dir1_out = 1'b1;
    settle();
    cyc();
    settle();
    check("pre-rst wb", 32'(ctl), 32'(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2,
                                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst wb ctl", 32'(ctl), 32'd0);
    check("rst hit_count", 32'(hit_count), 32'd0);
    check("rst miss_count", 32'(miss_count), 32'd0);
    m_hit = 16'd0; m_miss = 16'd0;
    cpu_read = 1'b0; lru_out = 1'b0; dir1_out = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("post-rst quiet", 32'(ctl), 32'd0);
      cyc();
    end

    // Hit counter saturation, preloaded near the top to keep the run short
    dut.r_hit_count <= 16'hFFFD;
    m_hit = 16'hFFFD;
    #1;
    check("preload hit_count", 32'(hit_count), 32'hFFFD);
    xact("sat hit 1", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 0, 0);
    xact("sat hit 2", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0);
    xact("sat hit 3", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0);
    xact("sat miss",  1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 0, 1);
    xact("sat hit 4", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 0, 0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
